// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes and FSM state encoding for seq_alu.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SRA  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_NOR  = 4'b1001,
        OP_SLTU = 4'b1010,
        OP_MULU = 4'b1100,
        OP_DIVU = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier and
// restoring divider. Loads on start, runs WIDTH steps, then pulses done
// for one cycle with {hi,lo} = product or {remainder,quotient}.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt;
    logic             div_q;
    logic [WIDTH-1:0] opd;     // multiplicand (mul) or divisor (div)
    logic [WIDTH:0]   madd;    // partial product plus multiplicand, with carry
    logic [WIDTH:0]   dsh;     // remainder shifted left with next dividend bit
    logic [WIDTH:0]   dsub;    // trial subtraction; MSB set means borrow

    // Step candidates for both algorithms; the sequencer picks one.
    always_comb begin
        madd = {1'b0, hi} + {1'b0, (lo[0] ? opd : {WIDTH{1'b0}})};
        dsh  = {hi, lo[WIDTH-1]};
        dsub = dsh - {1'b0, opd};
    end

    // Done is the cycle after the last step, while busy is still set.
    assign done = busy && (cnt == '0);

    // Load, iterate and count down; b==0 divides naturally to all-ones/a.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            div_q <= 1'b0;
            opd   <= '0;
            lo    <= '0;
            hi    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CNT_W'(WIDTH);
            div_q <= is_div;
            opd   <= is_div ? b : a;
            lo    <= is_div ? a : b;
            hi    <= '0;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
                if (div_q) begin
                    if (!dsub[WIDTH]) begin
                        hi <= dsub[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi <= dsh[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi <= madd[WIDTH:1];
                    lo <= {madd[0], lo[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready on both sides.
// Single-cycle ops complete in 1 cycle; MULU/DIVU take WIDTH+1 cycles
// when built with ALU_MULDIV_EN, otherwise they are flagged as illegal.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             err
);

    localparam int SHAMT_W = $clog2(WIDTH);

    alu_state_e       state;
    logic             accept;
    logic             is_md;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ill;
    logic [SHAMT_W-1:0] shamt;

    assign accept = in_valid && in_ready && (state == S_IDLE);
    assign shamt  = b[SHAMT_W-1:0];

`ifdef ALU_MULDIV_EN
    assign is_md = (op == OP_MULU) || (op == OP_DIVU);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_md),
        .is_div (op == OP_DIVU),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );
`else
    // Without the iterative unit MULU/DIVU fall through to the illegal path.
    assign is_md   = 1'b0;
    assign md_busy = 1'b0;
    assign md_done = 1'b0;
    assign md_lo   = '0;
    assign md_hi   = '0;
`endif

    // Single-cycle result; MULU/DIVU and unknown codes land in the illegal arm.
    always_comb begin
        sc_res = '0;
        sc_ill = 1'b0;
        case (alu_op_e'(op))
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $signed(a) >>> shamt;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            default: sc_ill = 1'b1;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            hi        <= '0;
            zero      <= 1'b1;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (is_md) begin
                            state <= S_BUSY;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            hi        <= '0;
                            zero      <= (sc_res == '0);
                            err       <= sc_ill;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (md_done) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= md_lo;
                        hi        <= md_hi;
                        zero      <= (md_lo == '0);
                        err       <= 1'b0;
                    end else if (!md_busy) begin
                        // Unit idle without a done pulse: recover rather than hang.
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed plus randomized checks of seq_alu against an
// arithmetic reference model. Follows ALU_MULDIV_EN like the design.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic          zero;
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: results straight from the op definitions.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [W-1:0] h,
                                  output logic e, output int lat);
        logic [63:0] p;
        int sh;
        r = '0; h = '0; e = 1'b0; lat = 1;
        sh = int'(y % 32);
        case (o)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2:  r = x + y;
            4'd3:  r = x << sh;
            4'd4:  r = x >> sh;
            4'd5:  r = $signed(x) >>> sh;
            4'd6:  r = x - y;
            4'd7:  r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd8:  r = x ^ y;
            4'd9:  r = ~(x | y);
            4'd10: r = (x < y) ? 1 : 0;
`ifdef ALU_MULDIV_EN
            4'd12: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0]; h = p[63:32]; lat = W + 1;
            end
            4'd13: begin
                if (y == 0) begin r = '1; h = x; end
                else begin r = x / y; h = x % y; end
                lat = W + 1;
            end
`endif
            default: e = 1'b1;
        endcase
    endfunction

    // Issue one op, measure latency, hold the result for `stall` cycles, retire it.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int stall);
        logic [W-1:0] er, eh;
        logic ee;
        int elat, lat, guard;
        model(o, x, y, er, eh, ee, elat);
        op = o; a = x; b = y; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        // garbage held on the inputs must be ignored while not ready
        op = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk); #1; lat++;
        end
        chk($sformatf("lat op%0d", o), lat, elat);
        chk($sformatf("res op%0d", o), result, er);
        chk($sformatf("hi op%0d", o), hi, eh);
        chk($sformatf("err op%0d", o), err, ee);
        chk($sformatf("zero op%0d", o), zero, (er == 0));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_res", result, er);
            chk("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("retire_valid", out_valid, 0);
        chk("retire_ready", in_ready, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        op = 4'd2; a = 1; b = 2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ready", in_ready, 0);
        chk("rst_res", result, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1);

        run_op(4'd6, 5, 7, 0);
        run_op(4'd7, 32'hFFFF_FFFF, 1, 0);
        run_op(4'd10, 32'hFFFF_FFFF, 1, 0);
        run_op(4'd5, 32'h8000_0000, 32'h24, 0);
        run_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'd13, 100, 7, 0);
        run_op(4'd13, 9, 0, 1);
        run_op(4'd2, 3, 4, 5);
        run_op(4'd15, 32'h1234, 32'h5678, 0);
        run_op(4'd3, 1, 32'hFFFF_FFE1, 0);

        for (int k = 0; k < 60; k++)
            run_op(4'($urandom), pick(), pick(), $urandom_range(0, 2));

        // reset in the middle of a MULU (or its illegal completion)
        op = 4'd12; a = $urandom; b = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_valid", seen, 0);
        chk("midrst_ready", in_ready, 1);
        run_op(4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
